data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/mem_pkg.sv | 14 +
 rtl/dm_word_array.sv | 30 +++
 rtl/data_mem_responder.sv | 120 ++++++++++++
 tb/tb_data_mem_responder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and defaults for the data memory responder
package mem_pkg;

  localparam int WORD_W          = 32;
  localparam int DEPTH_DEF       = 64;
  localparam int WAIT_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dm_word_array.sv
// rtl/dm_word_array.sv - word storage, synchronous single-port write, registered read
module dm_word_array
  import mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic              rzero,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Storage is deliberately left out of reset so contents survive an aborted access.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= rzero ? '0 : mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-state data memory responder for the MEM stage
// Optional misaligned-access checking is enabled by DATA_MEM_MISALIGN_CHECK_EN.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              stall,
  output logic              resp_err
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t            state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic              commit;
  logic              wr_q, mis_q, err_q;
  logic [AW-1:0]     idx_q;
  logic [WORD_W-1:0] wdata_q;
  logic              req_mis;
  logic              in_idle;
  logic              acc_wr, acc_mis;
  logic [AW-1:0]     acc_idx;
  logic [WORD_W-1:0] acc_wdata;
  logic              unused_addr;

`ifdef DATA_MEM_MISALIGN_CHECK_EN
  assign req_mis     = (req_addr[1:0] != 2'b00);
  assign unused_addr = ^req_addr[31:AW+2];
`else
  assign req_mis     = 1'b0;
  assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    commit   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_nx = RESP;
            commit   = 1'b1;
          end else begin
            state_nx = WAIT;
            cnt_nx   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nx = RESP;
          commit   = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // With zero wait states the commit edge is the acceptance edge, so bypass the capture regs.
  assign in_idle   = (state == IDLE);
  assign acc_wr    = in_idle ? req_write             : wr_q;
  assign acc_mis   = in_idle ? req_mis               : mis_q;
  assign acc_idx   = in_idle ? req_addr[AW+1:2]      : idx_q;
  assign acc_wdata = in_idle ? req_wdata             : wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      wr_q    <= 1'b0;
      mis_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (in_idle && req_valid) begin
        wr_q    <= req_write;
        mis_q   <= req_mis;
        idx_q   <= req_addr[AW+1:2];
        wdata_q <= req_wdata;
      end
      if (commit) err_q <= acc_mis;
    end
  end

  dm_word_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (commit & acc_wr & ~acc_mis),
    .re    (commit & ~acc_wr),
    .rzero (acc_mis),
    .addr  (acc_idx),
    .wdata (acc_wdata),
    .rdata (resp_rdata)
  );

  assign req_ready  = in_idle;
  assign resp_valid = (state == RESP);
  assign resp_err   = resp_valid & err_q;
  assign stall      = (in_idle & req_valid) | (state == WAIT);

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized scoreboard bench for data_mem_responder
module tb_data_mem_responder;

  localparam int DEPTH = 64;
  localparam int W     = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, resp_valid, stall, resp_err;
  logic [31:0] resp_rdata;

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .stall(stall), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_m [DEPTH];
  logic [31:0] last_rdata = '0;
  int          cyc = 0;
  int          acc_cycle = -1000;
  int          total = 0;
  int          bad = 0;
  bit          mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit model_idle();
    int d = cyc - acc_cycle;
    return !(d >= 1 && d <= W + 1);
  endfunction

  function automatic void model_accept(logic w, logic [31:0] a, logic [31:0] d);
    int   idx = int'((a >> 2) % DEPTH);
    bit   mis = 1'b0;
    exp_t e;
`ifdef DATA_MEM_MISALIGN_CHECK_EN
    mis = (a % 4) != 0;
`endif
    e.acc = cyc;
    e.err = mis;
    if (w) begin
      if (!mis) mem_m[idx] = d;
      e.rdata = last_rdata;
    end else begin
      e.rdata    = mis ? 32'h0 : mem_m[idx];
      last_rdata = e.rdata;
    end
    exp_q.push_back(e);
    acc_cycle = cyc;
  endfunction

  // Inputs change 1ns after the rising edge; the model decides acceptance on its own.
  task automatic step(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
    req_valid = v; req_write = w; req_addr = a; req_wdata = d;
    if (v && model_idle()) model_accept(w, a, d);
    @(posedge clk); #1;
  endtask

  task automatic op(input logic w, input logic [31:0] a, input logic [31:0] d);
    while (!model_idle()) step(1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, w, a, d);
    req_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    int d;
    bit in_wait, in_resp;
    exp_t e;
    if (mon_en) begin
      d       = cyc - acc_cycle;
      in_wait = (d >= 1 && d <= W);
      in_resp = (d == W + 1);
      chk("req_ready", {31'b0, req_ready}, {31'b0, !(in_wait || in_resp)});
      chk("stall", {31'b0, stall}, {31'b0, in_wait || (!in_resp && req_valid)});
      chk("resp_valid", {31'b0, resp_valid}, {31'b0, in_resp});
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 32'h1, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
          chk("latency", 32'(cyc - e.acc), 32'(W + 1));
        end
      end
    end
  end

  initial begin
    logic [31:0] old;
    repeat (3) begin
      @(negedge clk);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
      chk("rst_resp_rdata", resp_rdata, 32'h0);
      chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
      chk("rst_stall", {31'b0, stall}, 32'h0);
    end
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < DEPTH; i++) op(1'b1, 32'(i * 4), $urandom);

    op(1'b1, 32'h10, 32'hDEADBEEF);
    op(1'b0, 32'h10, 32'h0);
    op(1'b1, 32'h100, 32'h12345678);
    op(1'b0, 32'h000, 32'h0);

    while (!model_idle()) step(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 32'(i * 4), 32'h0);
    req_valid = 1'b0;

    // Abort a store in its first WAIT cycle; the old word must survive.
    old = mem_m[8];
    op(1'b1, 32'h20, 32'hAAAA5555);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_ready", {31'b0, req_ready}, 32'h1);
      chk("mid_rst_valid", {31'b0, resp_valid}, 32'h0);
      chk("mid_rst_rdata", resp_rdata, 32'h0);
    end
    @(posedge clk); #1;
    mem_m[8]   = old;
    void'(exp_q.pop_back());
    acc_cycle  = -1000;
    last_rdata = '0;
    rst_n      = 1'b1;
    mon_en     = 1'b1;
    op(1'b0, 32'h20, 32'h0);

    op(1'b1, 32'h22, 32'h1);
    op(1'b0, 32'h20, 32'h0);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, DEPTH - 1) * 4),
           $urandom);
    req_valid = 1'b0;
    repeat (W + 3) step(1'b0, 1'b0, 32'h0, 32'h0);
    chk("drain_empty", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
